inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the cpuSingleCycle datapath/decode. Used when the core moves to a fetch/decode split with a real instruction memory.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Accepts branch/jump redirects from the execute logic and squashes stale fetches.

Parameters:
ADDR_W  32  width of PC and imem_addr
DATA_W  32  instruction width
RESET_PC  32'h0000_0000  first fetch address after reset; low 2 bits must be 0

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  byte address of requested word; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful when imem_req=1
imem_rdata  input  DATA_W  instruction word, valid when imem_ack=1
inst_valid  output  1  inst/inst_pc hold a fetched instruction
inst_ready  input  1  decode accepts instruction this cycle
inst  output  DATA_W  fetched instruction
inst_pc  output  ADDR_W  address of inst
redirect  input  1  branch/jump taken; restart fetch at redirect_pc
redirect_pc  input  ADDR_W  redirect target; bits [1:0] forced to 0 internally

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge.
- Reset state:
  - pc=RESET_PC; state=S_IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
  - squash=0, pend_pc=0.
- Reset asserted in any state: all of the above on the next edge. An in-flight memory response is abandoned; an imem_ack arriving while reset=1 is ignored.
- S_IDLE: lasts one cycle, then S_WAIT. The first imem_req=1 appears in the second cycle after reset deasserts.
- S_WAIT:
  - imem_req=1, imem_addr=pc.
  - Address is held constant until imem_ack; a request is never withdrawn before ack.
  - On imem_ack with squash=0 and redirect=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go S_HOLD.
  - On imem_ack with squash=1 or redirect=1: data discarded, squash<=0, go S_GAP. pc<=pend_pc, or redirect_pc if redirect is high this cycle (newest wins).
  - redirect without imem_ack: squash<=1, pend_pc<=redirect_pc. A later redirect before ack overwrites pend_pc.
- S_HOLD:
  - imem_req=0, inst_valid=1; inst and inst_pc held stable until accepted.
  - inst_ready=1 and redirect=0: inst_valid<=0, pc<=pc+4 (mod 2^ADDR_W), go S_GAP.
  - redirect=1, regardless of inst_ready: instruction dropped, inst_valid<=0, pc<=redirect_pc, go S_GAP.
- S_GAP:
  - One cycle with imem_req=0, then S_WAIT.
  - redirect in S_GAP: pc<=redirect_pc. Last redirect before S_WAIT wins.
- Latency and throughput: with ack in the first request cycle and inst_ready held 1, one instruction per 3 cycles (WAIT, HOLD, GAP).
- Invariants:
  - imem_req and inst_valid are never both 1.
  - inst_pc[1:0]=0 always.
  - No instruction from before a redirect is presented after it.
- Arithmetic: pc increment wraps from 2^ADDR_W-4 to 0, with no flag.

Test Plan:
- Reset then fixed-latency memory: ack 1 cycle after req, rdata=addr^32'hA5A5_0000, inst_ready=1 → inst_pc sequence 0,4,8,C, each inst matching; first imem_req in the 2nd cycle after reset drops.
- Backpressure: inst_ready=0 for 5 cycles at inst_pc=8 → inst_valid stays 1, inst/inst_pc stable, imem_req=0 throughout; after ready, next imem_addr=C.
- Redirect while waiting (ack latency 4), redirect=1 with redirect_pc=0x103 at cycle 2 of wait → returned word discarded (inst_valid stays 0), next imem_addr=0x100, next inst_pc=0x100.
- Redirect on the same cycle as inst_ready in S_HOLD, redirect_pc=0x40 → held instruction not counted, next fetch at 0x40 (not pc+4).
- Wrap: RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-S_WAIT with ack arriving the same cycle → outputs return to reset values next cycle, no inst_valid pulse; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Summary  : PC owner and instruction fetch stage. Handles variable-latency
//            req/ack imem, valid/ready decode handoff, and redirects.
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]   r_pend_pc, w_pend_pc_nxt;
    logic                r_squash, w_squash_nxt;
    logic [DATA_W-1:0]   r_inst, w_inst_nxt;
    logic [ADDR_W-1:0]   r_inst_pc, w_inst_pc_nxt;
    logic [ADDR_W-1:0]   w_redir_pc;

    assign w_redir_pc = redirect_pc & c_align_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
            r_squash  <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_squash  <= w_squash_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_pc_nxt = r_pend_pc;
        w_squash_nxt  = r_squash;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        case (r_state)
            S_IDLE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    if (!r_squash && !redirect) begin
                        w_inst_nxt    = imem_rdata;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = S_HOLD;
                    end else begin
                        // A redirect in the ack cycle is newer than any pending one
                        w_squash_nxt = 1'b0;
                        w_pc_nxt     = redirect ? w_redir_pc : r_pend_pc;
                        w_state_nxt  = S_GAP;
                    end
                end else if (redirect) begin
                    // Request must stay stable until ack, so remember the target
                    w_squash_nxt  = 1'b1;
                    w_pend_pc_nxt = w_redir_pc;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_GAP;
                end else if (inst_ready) begin
                    w_pc_nxt    = r_pc + c_pc_step;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                end
                w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign imem_req   = (r_state == S_WAIT);
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == S_HOLD);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Summary  : Directed self-checking bench for inst_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] c_xor = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;

    logic        imem_req2, imem_ack2, inst_valid2;
    logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;
    logic        inst_ready2 = 1'b1;
    logic        redirect2   = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;

    int          lat;
    int          cnt;
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    inst_fetch_unit u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2),
        .inst(inst2), .inst_pc(inst_pc2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    // Memory model: ack after lat extra request cycles, data = addr ^ c_xor
    always @(posedge clk) begin
        if (!imem_req || imem_ack) cnt <= 0;
        else                       cnt <= cnt + 1;
    end
    assign imem_ack    = imem_req && (cnt == lat);
    assign imem_rdata  = imem_addr ^ c_xor;
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = imem_addr2 ^ c_xor;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(output int n);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (inst_valid) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid); else n_pass++;
        n_total++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else n_pass++;
        n_total++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", inst_pc); else n_pass++;
        reset = 1'b0;
        n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %0b want 0", imem_req); else n_pass++;
        step();
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %0b want 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", imem_addr); else n_pass++;
    endtask

    task automatic test_fetch();
        int n;
        for (int k = 0; k < 2; k++) begin
            wait_inst(n);
            n_total++; if (n !== ((k == 0) ? 2 : 4)) $display("FAIL fetch_latency%0d: got %0d want %0d", k, n, (k == 0) ? 2 : 4); else n_pass++;
            n_total++; if (inst_pc !== 32'(4 * k)) $display("FAIL fetch_pc%0d: got %h want %h", k, inst_pc, 32'(4 * k)); else n_pass++;
            n_total++; if (inst !== (32'(4 * k) ^ c_xor)) $display("FAIL fetch_inst%0d: got %h want %h", k, inst, 32'(4 * k) ^ c_xor); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        step();
        inst_ready = 1'b0;
        wait_inst(n);
        n_total++; if (inst_pc !== 32'h8) $display("FAIL bp_pc: got %h want 8", inst_pc); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (inst_valid !== 1'b1) $display("FAIL bp_valid%0d: got %0b want 1", i, inst_valid); else n_pass++;
            n_total++; if (inst_pc !== 32'h8) $display("FAIL bp_hold_pc%0d: got %h want 8", i, inst_pc); else n_pass++;
            n_total++; if (inst !== 32'hA5A5_0008) $display("FAIL bp_hold_inst%0d: got %h want a5a50008", i, inst); else n_pass++;
            n_total++; if (imem_req !== 1'b0) $display("FAIL bp_req%0d: got %0b want 0", i, imem_req); else n_pass++;
        end
        inst_ready = 1'b1;
        step();
        n_total++; if (inst_valid !== 1'b0) $display("FAIL bp_release: got %0b want 0", inst_valid); else n_pass++;
        step();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) $display("FAIL bp_next_addr: got req=%0b addr=%h want req=1 addr=c", imem_req, imem_addr); else n_pass++;
        wait_inst(n);
        n_total++; if (inst_pc !== 32'hC) $display("FAIL bp_next_pc: got %h want c", inst_pc); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int  n;
        bit  saw_valid;
        lat = 4;
        step();
        step();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL rw_start: got req=%0b addr=%h want req=1 addr=10", imem_req, imem_addr); else n_pass++;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect    = 1'b0;
        saw_valid   = 1'b0;
        n = 0;
        while (n < 20 && !(imem_req && imem_addr != 32'h10)) begin
            step();
            n++;
            if (inst_valid) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL rw_discard: got valid pulse=1 want 0"); else n_pass++;
        n_total++; if (n !== 4) $display("FAIL rw_cycles: got %0d want 4", n); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL rw_addr: got %h want 100", imem_addr); else n_pass++;
        lat = 1;
        wait_inst(n);
        n_total++; if (inst_pc !== 32'h100) $display("FAIL rw_pc: got %h want 100", inst_pc); else n_pass++;
        n_total++; if (inst !== 32'hA5A5_0100) $display("FAIL rw_inst: got %h want a5a50100", inst); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        int n;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect    = 1'b0;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL rh_drop: got %0b want 0", inst_valid); else n_pass++;
        step();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) $display("FAIL rh_addr: got req=%0b addr=%h want req=1 addr=40", imem_req, imem_addr); else n_pass++;
        wait_inst(n);
        n_total++; if (inst_pc !== 32'h40) $display("FAIL rh_pc: got %h want 40", inst_pc); else n_pass++;
    endtask

    task automatic test_redirect_gap();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        step();
        redirect    = 1'b0;
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) $display("FAIL rg_addr: got req=%0b addr=%h want req=1 addr=200", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[3];
        int          got;
        reset = 1'b1;
        step();
        reset = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && got < 3; i++) begin
            step();
            if (imem_req2) begin
                addrs[got] = imem_addr2;
                got++;
            end
        end
        n_total++; if (got !== 3) $display("FAIL wrap_count: got %0d want 3", got); else n_pass++;
        n_total++; if (addrs[0] !== 32'hFFFF_FFF8) $display("FAIL wrap_a0: got %h want fffffff8", addrs[0]); else n_pass++;
        n_total++; if (addrs[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_a1: got %h want fffffffc", addrs[1]); else n_pass++;
        n_total++; if (addrs[2] !== 32'h0) $display("FAIL wrap_a2: got %h want 0", addrs[2]); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        lat   = 3;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_total++; if ({imem_req, imem_ack} !== 2'b11) $display("FAIL rm_ack_cycle: got req/ack=%b want 11", {imem_req, imem_ack}); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", inst_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rm_req: got %0b want 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL rm_addr: got %h want 0", imem_addr); else n_pass++;
        n_total++; if (inst !== 32'h0) $display("FAIL rm_inst: got %h want 0", inst); else n_pass++;
        n_total++; if (inst_pc !== 32'h0) $display("FAIL rm_inst_pc: got %h want 0", inst_pc); else n_pass++;
        step();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL rm_restart: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr); else n_pass++;
        lat = 1;
        wait_inst(n);
        n_total++; if (n !== 2) $display("FAIL rm_latency: got %0d want 2", n); else n_pass++;
        n_total++; if (inst !== 32'hA5A5_0000) $display("FAIL rm_first_inst: got %h want a5a50000", inst); else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = 1;
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_gap();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
